// File: rtl/iq_sample_packer_if.sv
// Sample input and AXI4-Stream output bundle for iq_sample_packer.
// The master side is the packer: it consumes samples and drives the stream.
// Stream handshake: a word transfers on any rising edge where m_tvalid and
// m_tready are both high; once m_tvalid rises it stays high, with m_tdata and
// m_tlast held constant, until that transfer happens. m_tvalid never waits
// for m_tready.
interface iq_sample_packer_if;
    logic       dv_in;
    logic [2:0] real_in;
    logic [2:0] imag_in;
    logic [31:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;

    modport master (
        input  dv_in,
        input  real_in,
        input  imag_in,
        input  m_tready,
        output m_tdata,
        output m_tvalid,
        output m_tlast
    );

    modport slave (
        output dv_in,
        output real_in,
        output imag_in,
        output m_tready,
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast
    );
endinterface

// File: rtl/iq_sample_packer.sv
// Packs five 3-bit I/Q pairs per 32-bit word (2-bit sequence number on top),
// buffers words in a first-word-fall-through FIFO and streams them out with a
// tlast every PKT_WORDS accepted words. Dropped words set a sticky overflow.
module iq_sample_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_WORDS  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear_ovf,
    output logic        overflow,
    output logic [31:0] word_count,
    iq_sample_packer_if.master bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [PW-1:0] PKT_LAST = PW'(PKT_WORDS - 1);

    // Packing state
    logic [2:0]    slot;
    logic [23:0]   partial;
    logic [1:0]    seq;
    logic [PW-1:0] pkt_idx;

    // FIFO storage: bit 32 is tlast, bits 31:0 the packed word
    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    logic          empty;
    logic          full;
    logic          pop;
    logic          accept;
    logic          word_done;
    logic          push;
    logic          drop;
    logic [32:0]   new_entry;
    logic [32:0]   head;

    // FIFO status, handshake decode and the word being completed this cycle
    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop       = !empty && bus.m_tready;
        accept    = enable && bus.dv_in;
        word_done = accept && (slot == 3'd4);
        // A pop frees a slot at the same edge, so a full FIFO can still take
        // the word; an empty FIFO cannot pop, so that case never collides.
        push      = word_done && (!full || pop);
        drop      = word_done && !push;
        new_entry = {(pkt_idx == PKT_LAST), seq, bus.real_in, bus.imag_in, partial};
        head      = mem[rd_ptr[AW-1:0]];
    end

    // Stream outputs come straight from the FIFO head; zero while empty
    always_comb begin
        bus.m_tvalid = !empty;
        bus.m_tdata  = empty ? 32'd0 : head[31:0];
        bus.m_tlast  = !empty && head[32];
    end

    // Slot counter and partial word; disable discards the partial word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot    <= 3'd0;
            partial <= 24'd0;
        end else if (!enable) begin
            slot    <= 3'd0;
            partial <= 24'd0;
        end else if (accept) begin
            if (slot == 3'd4) begin
                // Wraps whether the word was stored or dropped
                slot    <= 3'd0;
                partial <= 24'd0;
            end else begin
                slot <= slot + 3'd1;
                case (slot)
                    3'd0:    partial[5:0]   <= {bus.real_in, bus.imag_in};
                    3'd1:    partial[11:6]  <= {bus.real_in, bus.imag_in};
                    3'd2:    partial[17:12] <= {bus.real_in, bus.imag_in};
                    default: partial[23:18] <= {bus.real_in, bus.imag_in};
                endcase
            end
        end
    end

    // Sequence number, packet position and word count advance only on stored words
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq        <= 2'd0;
            pkt_idx    <= '0;
            word_count <= 32'd0;
        end else if (!enable) begin
            pkt_idx <= '0;
        end else if (push) begin
            seq        <= seq + 2'd1;
            word_count <= word_count + 32'd1;
            pkt_idx    <= (pkt_idx == PKT_LAST) ? '0 : pkt_idx + 1'b1;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage write; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= new_entry;
    end

    // Sticky overflow; a drop in the same cycle wins over the clear pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          overflow <= 1'b0;
        else if (drop)      overflow <= 1'b1;
        else if (clear_ovf) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_iq_sample_packer.sv
// Directed bench for iq_sample_packer with a reference model and an
// expected-word queue compared against every stream cycle.
module tb_iq_sample_packer;

    localparam int DEPTH = 4;
    localparam int PKT   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear_ovf;
    logic        overflow;
    logic [31:0] word_count;

    iq_sample_packer_if bus ();

    iq_sample_packer #(
        .FIFO_DEPTH(DEPTH),
        .PKT_WORDS (PKT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clear_ovf (clear_ovf),
        .overflow  (overflow),
        .word_count(word_count),
        .bus       (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard and model state
    logic [32:0] exp_q[$];
    int          m_slot;
    logic [23:0] m_partial;
    logic [1:0]  m_seq;
    int          m_pkt;
    logic        m_ovf;
    logic [31:0] m_wc;
    int          checks;
    int          failures;
    int          tlast_seen;
    logic [31:0] wc_mark;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs, advance the model
    task automatic cycle(input logic en, input logic dv, input logic [2:0] re,
                         input logic [2:0] im, input logic rdy, input logic clr);
        logic pop;
        logic full;
        logic drop;
        @(negedge clk);
        enable      = en;
        bus.dv_in   = dv;
        bus.real_in = re;
        bus.imag_in = im;
        bus.m_tready = rdy;
        clear_ovf   = clr;
        #1;
        check("tvalid", {63'd0, bus.m_tvalid}, {63'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check("tdata", {32'd0, bus.m_tdata}, {32'd0, exp_q[0][31:0]});
            check("tlast", {63'd0, bus.m_tlast}, {63'd0, exp_q[0][32]});
        end
        check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
        check("word_count", {32'd0, word_count}, {32'd0, m_wc});
        if (bus.m_tvalid && rdy && bus.m_tlast) tlast_seen++;
        pop  = (exp_q.size() != 0) && rdy;
        full = (exp_q.size() == DEPTH);
        drop = 1'b0;
        if (pop) void'(exp_q.pop_front());
        if (!en) begin
            m_slot = 0;
            m_pkt  = 0;
        end else if (dv) begin
            if (m_slot == 4) begin
                if (!full || pop) begin
                    exp_q.push_back({(m_pkt == PKT - 1), m_seq, re, im, m_partial});
                    m_seq = m_seq + 2'd1;
                    m_wc  = m_wc + 32'd1;
                    m_pkt = (m_pkt == PKT - 1) ? 0 : m_pkt + 1;
                end else begin
                    drop = 1'b1;
                end
                m_slot = 0;
            end else begin
                m_partial[m_slot*6 +: 6] = {re, im};
                m_slot++;
            end
        end
        if (drop)     m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic sample(input logic rdy, input logic clr);
        logic [2:0] r;
        logic [2:0] q;
        r = 3'($urandom_range(0, 7));
        q = 3'($urandom_range(0, 7));
        cycle(1'b1, 1'b1, r, q, rdy, clr);
    endtask

    // Drain with enable low; bounded so a stuck stream cannot hang the run
    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++)
            cycle(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
    endtask

    // Asynchronous reset pulse with output checks while it is held
    task automatic apply_reset();
        @(negedge clk);
        reset        = 1'b1;
        enable       = 1'b0;
        bus.dv_in    = 1'b0;
        bus.m_tready = 1'b0;
        clear_ovf    = 1'b0;
        #1;
        check("rst_tvalid", {63'd0, bus.m_tvalid}, 64'd0);
        check("rst_tlast", {63'd0, bus.m_tlast}, 64'd0);
        check("rst_tdata", {32'd0, bus.m_tdata}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_word_count", {32'd0, word_count}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_slot = 0;
        m_seq  = 2'd0;
        m_pkt  = 0;
        m_ovf  = 1'b0;
        m_wc   = 32'd0;
    endtask

    logic [2:0] t1_i [5];
    logic [2:0] t1_q [5];

    initial begin
        checks     = 0;
        failures   = 0;
        tlast_seen = 0;
        m_partial  = 24'd0;
        reset        = 1'b0;
        enable       = 1'b0;
        clear_ovf    = 1'b0;
        bus.dv_in    = 1'b0;
        bus.real_in  = 3'd0;
        bus.imag_in  = 3'd0;
        bus.m_tready = 1'b0;
        apply_reset();

        // Known word: (1,-1),(2,-2),(3,-3),(-4,0),(0,1)
        t1_i = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        t1_q = '{3'd7, 3'd6, 3'd5, 3'd0, 3'd1};
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, t1_i[k], t1_q[k], 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        check("t1_word", {32'd0, bus.m_tdata}, 64'h0181_D58F);
        check("t1_valid", {63'd0, bus.m_tvalid}, 64'd1);
        check("t1_count", {32'd0, word_count}, 64'd1);
        drain();

        // Stalled stream: DEPTH words kept, later words dropped, seq gap-free
        for (int k = 0; k < 5 * (DEPTH + 1); k++) sample(1'b0, 1'b0);
        cycle(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        check("t2_overflow", {63'd0, overflow}, 64'd1);
        check("t2_count", {32'd0, word_count}, 64'(1 + DEPTH));
        drain();
        cycle(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
        check("t2_cleared", {63'd0, overflow}, 64'd0);

        // Packet boundaries: 12 words, tlast on words 3, 7, 11
        tlast_seen = 0;
        for (int k = 0; k < 60; k++) sample(1'b1, 1'b0);
        drain();
        check("t3_tlast_count", 64'(tlast_seen), 64'd3);

        // Partial word discarded by a one-cycle disable
        wc_mark = word_count;
        for (int k = 0; k < 3; k++) sample(1'b1, 1'b0);
        cycle(1'b0, 1'b1, 3'd3, 3'd3, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) sample(1'b1, 1'b0);
        drain();
        check("t4_count", {32'd0, word_count}, {32'd0, wc_mark + 32'd1});

        // Full FIFO with a simultaneous pop accepts the word
        for (int k = 0; k < 5 * DEPTH; k++) sample(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) sample(1'b0, 1'b0);
        sample(1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        check("t5_no_overflow", {63'd0, overflow}, 64'd0);
        // Drop coincident with clear_ovf keeps overflow set
        for (int k = 0; k < 4; k++) sample(1'b0, 1'b0);
        sample(1'b0, 1'b1);
        cycle(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        check("t5_set_wins", {63'd0, overflow}, 64'd1);
        drain();

        // Reset mid-word with words pending
        for (int k = 0; k < 7; k++) sample(1'b0, 1'b0);
        check("t6_pre_valid", {63'd0, bus.m_tvalid}, 64'd1);
        apply_reset();
        for (int k = 0; k < 5; k++) sample(1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        check("t6_seq0", {62'd0, bus.m_tdata[31:30]}, 64'd0);
        check("t6_count", {32'd0, word_count}, 64'd1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
